// File: rtl/contador_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable counter.
// Channel 0 drives the VGA pixel enable and channel 1 drives the alarm ring clock.
package contador_pkg;

    localparam int CNT_W_DEF = 32'sd24;
    localparam int DIV_PIXEL = 32'sd4;
    localparam int DIV_RING  = 32'sd12500000;
    localparam int CH_PIXEL  = 32'sd0;
    localparam int CH_RING   = 32'sd1;

    // Smallest r with 2**r >= value; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 32'sd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/contador_clk_multi_canal.sv
// One clock-enable channel: programmable divisor, one-shot/continuous mode,
// pause, synchronous clear, and a pending-divisor slot applied at safe points.
module contador_canal
    import contador_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_PIXEL)
) (
    input  logic             CLK_NX,
    input  logic             reset,
    input  logic             en,
    input  logic             oneshot,
    input  logic             clr,
    input  logic             wr_sel,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_r, div_act_r, div_pend_r;
    logic             pend_r, done_r, en_d_r, tick_r, sq_r, busy_r;

    logic [CNT_W-1:0] eff_div_s, eff_pend_s;
    logic             rise_s, done_eff_s, adv_s, wrap_s, apply_s;

    logic [CNT_W-1:0] cnt_nxt_s, div_act_nxt_s, div_pend_nxt_s;
    logic             pend_nxt_s, done_nxt_s, tick_nxt_s, sq_nxt_s;

    // Advance/wrap decision; a zero divisor behaves as one.
    always_comb begin
        eff_div_s  = (div_act_r == '0) ? CNT_W'(1) : div_act_r;
        eff_pend_s = (div_pend_r == '0) ? CNT_W'(1) : div_pend_r;
        rise_s     = en & ~en_d_r;
        // done survives only while still in one-shot mode and en has not re-risen
        done_eff_s = done_r & oneshot & ~rise_s;
        adv_s      = en & ~done_eff_s;
        wrap_s     = adv_s & (cnt_r >= (eff_div_s - CNT_W'(1)));
    end

    // Next-state for counter, outputs and divisor slots; clr beats wrap.
    always_comb begin
        cnt_nxt_s      = cnt_r;
        div_act_nxt_s  = div_act_r;
        div_pend_nxt_s = div_pend_r;
        pend_nxt_s     = pend_r;
        done_nxt_s     = done_eff_s;
        tick_nxt_s     = 1'b0;
        sq_nxt_s       = sq_r;
        apply_s        = 1'b0;

        if (clr) begin
            cnt_nxt_s  = '0;
            sq_nxt_s   = 1'b0;
            done_nxt_s = 1'b0;
            apply_s    = pend_r;
        end else if (wrap_s) begin
            cnt_nxt_s  = '0;
            tick_nxt_s = 1'b1;
            sq_nxt_s   = ~sq_r;
            done_nxt_s = oneshot;
            apply_s    = pend_r;
        end else if (adv_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            apply_s = pend_r;
            // idle apply of a shorter divisor must not leave cnt beyond the new period
            if (pend_r && (eff_pend_s <= cnt_r)) begin
                cnt_nxt_s = '0;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end

        if (apply_s) begin
            div_act_nxt_s = div_pend_r;
            pend_nxt_s    = 1'b0;
        end else begin
            div_act_nxt_s = div_act_r;
        end

        // a write on this edge lands in the pending slot after any apply above
        if (wr_sel) begin
            div_pend_nxt_s = wr_div;
            pend_nxt_s     = 1'b1;
        end else begin
            div_pend_nxt_s = div_pend_r;
        end
    end

    // Channel state register with synchronous reset.
    always_ff @(posedge CLK_NX) begin
        if (reset) begin
            cnt_r      <= '0;
            div_act_r  <= DIV_INIT;
            div_pend_r <= DIV_INIT;
            pend_r     <= 1'b0;
            done_r     <= 1'b0;
            en_d_r     <= 1'b0;
            tick_r     <= 1'b0;
            sq_r       <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            div_act_r  <= div_act_nxt_s;
            div_pend_r <= div_pend_nxt_s;
            pend_r     <= pend_nxt_s;
            done_r     <= done_nxt_s;
            en_d_r     <= en;
            tick_r     <= tick_nxt_s;
            sq_r       <= sq_nxt_s;
            busy_r     <= adv_s;
        end
    end

    assign tick = tick_r;
    assign sq   = sq_r;
    assign busy = busy_r;

endmodule

// File: rtl/contador_clk_multi.sv
// N_CH-channel clock-enable generator: write decode, acknowledge and one
// contador_canal per channel.
module contador_clk_multi
    import contador_pkg::*;
#(
    parameter int                    N_CH    = 2,
    parameter int                    CNT_W   = CNT_W_DEF,
    parameter int                    CH_W    = (clog2(N_CH) > 1) ? clog2(N_CH) : 1,
    parameter logic [N_CH*CNT_W-1:0] DIV_RST = {CNT_W'(DIV_RING), CNT_W'(DIV_PIXEL)}
) (
    input  logic             CLK_NX,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic [N_CH-1:0]  oneshot,
    input  logic [N_CH-1:0]  clr,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    output logic             wr_ack,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq,
    output logic [N_CH-1:0]  busy
);

    localparam logic [CH_W:0] N_CH_V = (CH_W + 1)'(N_CH);

    logic            wr_valid_s;
    logic [N_CH-1:0] wr_sel_s;
    logic            wr_ack_r;

    // Decode the write strobe to a one-hot channel select; out-of-range channels are dropped.
    always_comb begin
        wr_valid_s = wr_en & ({1'b0, wr_ch} < N_CH_V);
        wr_sel_s   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_valid_s && (wr_ch == CH_W'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    // One-cycle acknowledge for every accepted write.
    always_ff @(posedge CLK_NX) begin
        if (reset) begin
            wr_ack_r <= 1'b0;
        end else begin
            wr_ack_r <= wr_valid_s;
        end
    end

    assign wr_ack = wr_ack_r;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        contador_canal #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_RST[g*CNT_W +: CNT_W])
        ) u_canal (
            .CLK_NX  (CLK_NX),
            .reset   (reset),
            .en      (en[g]),
            .oneshot (oneshot[g]),
            .clr     (clr[g]),
            .wr_sel  (wr_sel_s[g]),
            .wr_div  (wr_div),
            .tick    (tick[g]),
            .sq      (sq[g]),
            .busy    (busy[g])
        );
    end

endmodule
